axlite_wb_master: RTL and testbench
===================================

// Module: axlite_wb_master
// PURPOSE
//  AXI4-Lite slave to Wishbone pipelined master bridge, single transaction in flight.
//  Converts host AXI-Lite reads/writes into WB cycles.
//  Drives one master port (A or B) of the downstream two-master WB arbiter.
//  Guarantees o_wb_cyc drops for >=1 clock between cycles, so the arbiter can re-arbitrate.
// PARAMETERS
//  C_AXI_ADDR_WIDTH  28  AXI byte-address width; WB word address = awaddr/araddr[ADDR_W-1:2]
//  C_AXI_DATA_WIDTH  32  AXI and WB data width; must be 32 or 64
//  TIMEOUT           0   max clocks o_wb_cyc may stay high awaiting ack/err; 0 = no timeout
// PORTS
//  i_clk          in   1        clock
//  i_reset        in   1        synchronous, active-high reset
//  s_axi_awvalid  in   1        write address valid
//  s_axi_awready  out  1        write address ready
//  s_axi_awaddr   in   ADDR_W   write byte address
//  s_axi_awprot   in   3        ignored
//  s_axi_wvalid   in   1        write data valid
//  s_axi_wready   out  1        write data ready
//  s_axi_wdata    in   DATA_W   write data
//  s_axi_wstrb    in   DATA_W/8 byte strobes -> o_wb_sel
//  s_axi_bvalid   out  1        write response valid
//  s_axi_bready   in   1        write response ready
//  s_axi_bresp    out  2        00 OKAY, 10 SLVERR
//  s_axi_arvalid  in   1        read address valid
//  s_axi_arready  out  1        read address ready
//  s_axi_araddr   in   ADDR_W   read byte address
//  s_axi_arprot   in   3        ignored
//  s_axi_rvalid   out  1        read data valid
//  s_axi_rready   in   1        read data ready
//  s_axi_rdata    out  DATA_W   read data
//  s_axi_rresp    out  2        00 OKAY, 10 SLVERR
//  o_wb_cyc, o_wb_stb, o_wb_we  out  1  WB cycle, strobe, write enable
//  o_wb_adr       out  ADDR_W-2 WB word address
//  o_wb_dat       out  DATA_W   WB write data
//  o_wb_sel       out  DATA_W/8 WB byte selects
//  i_wb_ack, i_wb_stall, i_wb_err  in  1  WB ack, stall, error
//  i_wb_data      in   DATA_W   WB read data
// BEHAVIOUR
//  FSM: IDLE -> STB -> ACK -> RESP -> IDLE. A type flag (rd/wr) selects B or R channel.
//  Reset: state IDLE; cyc, stb, bvalid, rvalid = 0; bresp/rresp = 00; rdata = 0; last_rd = 1.
//  Reset mid-cycle drops o_wb_cyc on the next clock. Pending responses are discarded.
//  IDLE accept rules (readies are combinational, asserted only in IDLE):
//   - Write: accepted only when awvalid && wvalid in the same clock. awready = wready = 1 together.
//   - Read: arready = 1 when arvalid.
//   - Both pending: alternate, using last_rd (write wins if last was a read, else read wins).
//  Accept clock: latch adr, dat, sel, we. Next clock: cyc = stb = 1 (state STB).
//  STB: stb held until !i_wb_stall, then stb = 0 (state ACK); cyc stays 1.
//  ACK or ERR may arrive in STB (same clock stb is accepted) or in ACK.
//  On ack/err: cyc = 0 next clock, enter RESP; resp = err ? 10 : 00.
//   - Read: rdata <= ack ? i_wb_data : 0.
//  RESP: bvalid/rvalid held with stable resp/data until bready/rready, then IDLE.
//   - Minimum cyc-low gap = 1 clock (RESP lasts >= 1 clock).
//  Timeout (TIMEOUT > 0): counter clears on accept and increments each clock cyc = 1.
//   - If it reaches TIMEOUT with no ack/err: drop cyc and stb, RESP with SLVERR, rdata = 0.
//  Ack/err when cyc = 0: ignored. Ack and err together: treated as err.
//  Best-case latency: accept@0, cyc/stb@1 with ack@1, bvalid/rvalid@2.
// TESTING
//  1. Write awaddr=0x10, wdata=0xCAFEF00D, wstrb=0xF, slave acks @1 -> adr=0x4, sel=0xF, bvalid@2, bresp=00.
//  2. Read araddr=0x8, stall 3 clocks, ack +2 with data 0x12345678 -> stb 4 clocks, rdata=0x12345678, rresp=00.
//  3. Write with i_wb_err instead of ack -> bresp=10; cyc low next clock; next txn is accepted.
//  4. aw/w and ar both valid continuously for 4 txns -> order W,R,W,R; cyc low >=1 clock between each.
//  5. TIMEOUT=8, read, slave never acks -> cyc falls 8 clocks after rising; rresp=10, rdata=0.
//  6. i_reset during ACK with rready=0 -> cyc=0 next clock, no rvalid, IDLE accepts a new read.

Source files
------------

// File: rtl/axlite_wb_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : axlite_wb_master_if
//  Description : Bus bundle for the AXI4-Lite to Wishbone bridge. It carries
//                the AXI4-Lite slave channels and the Wishbone master port.
//                master : the bridge's view (it answers AXI, drives WB)
//                slave  : the environment's view (AXI host + WB slave)
//  Revision    : 1.0  initial release
// ============================================================================
interface axlite_wb_master_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 32
);
    // AXI4-Lite write address / data / response
    logic                  s_axi_awvalid;
    logic                  s_axi_awready;
    logic [ADDR_W-1:0]     s_axi_awaddr;
    logic [2:0]            s_axi_awprot;
    logic                  s_axi_wvalid;
    logic                  s_axi_wready;
    logic [DATA_W-1:0]     s_axi_wdata;
    logic [DATA_W/8-1:0]   s_axi_wstrb;
    logic                  s_axi_bvalid;
    logic                  s_axi_bready;
    logic [1:0]            s_axi_bresp;
    // AXI4-Lite read address / data
    logic                  s_axi_arvalid;
    logic                  s_axi_arready;
    logic [ADDR_W-1:0]     s_axi_araddr;
    logic [2:0]            s_axi_arprot;
    logic                  s_axi_rvalid;
    logic                  s_axi_rready;
    logic [DATA_W-1:0]     s_axi_rdata;
    logic [1:0]            s_axi_rresp;
    // Wishbone pipelined master port
    logic                  o_wb_cyc;
    logic                  o_wb_stb;
    logic                  o_wb_we;
    logic [ADDR_W-3:0]     o_wb_adr;
    logic [DATA_W-1:0]     o_wb_dat;
    logic [DATA_W/8-1:0]   o_wb_sel;
    logic                  i_wb_ack;
    logic                  i_wb_stall;
    logic                  i_wb_err;
    logic [DATA_W-1:0]     i_wb_data;

    modport master (
        input  s_axi_awvalid, s_axi_awaddr, s_axi_awprot,
        output s_axi_awready,
        input  s_axi_wvalid, s_axi_wdata, s_axi_wstrb,
        output s_axi_wready,
        output s_axi_bvalid, s_axi_bresp,
        input  s_axi_bready,
        input  s_axi_arvalid, s_axi_araddr, s_axi_arprot,
        output s_axi_arready,
        output s_axi_rvalid, s_axi_rdata, s_axi_rresp,
        input  s_axi_rready,
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel,
        input  i_wb_ack, i_wb_stall, i_wb_err, i_wb_data
    );

    modport slave (
        output s_axi_awvalid, s_axi_awaddr, s_axi_awprot,
        input  s_axi_awready,
        output s_axi_wvalid, s_axi_wdata, s_axi_wstrb,
        input  s_axi_wready,
        input  s_axi_bvalid, s_axi_bresp,
        output s_axi_bready,
        output s_axi_arvalid, s_axi_araddr, s_axi_arprot,
        input  s_axi_arready,
        input  s_axi_rvalid, s_axi_rdata, s_axi_rresp,
        output s_axi_rready,
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel,
        output i_wb_ack, i_wb_stall, i_wb_err, i_wb_data
    );
endinterface
`default_nettype wire

// File: rtl/axlite_wb_master.sv
`default_nettype none
// ============================================================================
//  Module      : axlite_wb_master
//  Description : AXI4-Lite slave to Wishbone pipelined master bridge with a
//                single transaction in flight. Reads and writes alternate
//                when both are pending; cyc always drops for at least one
//                clock between cycles so a downstream arbiter can re-grant.
//  Revision    : 1.0  initial release
// ============================================================================
module axlite_wb_master #(
    parameter int C_AXI_ADDR_WIDTH = 28,
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT          = 0
) (
    input  wire logic           i_clk,
    input  wire logic           i_reset,
    axlite_wb_master_if.master  bus
);
    localparam int          AW       = C_AXI_ADDR_WIDTH;
    localparam int          DW       = C_AXI_DATA_WIDTH;
    localparam int          SW       = DW / 8;
    localparam logic [1:0]  C_OKAY   = 2'b00;
    localparam logic [1:0]  C_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STB  = 2'd1,
        S_ACK  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [AW-3:0]   r_adr;
    logic [DW-1:0]   r_dat;
    logic [SW-1:0]   r_sel;
    logic            r_we;
    logic            r_is_rd;
    logic            r_last_rd;
    logic [1:0]      r_resp;
    logic [DW-1:0]   r_rdata;

    logic            w_idle;
    logic            w_busy;
    logic            w_wr_req;
    logic            w_rd_req;
    logic            w_acc_wr;
    logic            w_acc_rd;
    logic            w_accept;
    logic            w_term;
    logic            w_timeout;
    logic            w_resp_taken;

    // Protection bits and the byte offset within a word carry no meaning here
    logic            w_unused;
    assign w_unused = ^{bus.s_axi_awprot, bus.s_axi_arprot,
                        bus.s_axi_awaddr[1:0], bus.s_axi_araddr[1:0]};

    assign w_idle   = (r_state == S_IDLE);
    assign w_busy   = (r_state == S_STB) || (r_state == S_ACK);
    assign w_wr_req = bus.s_axi_awvalid && bus.s_axi_wvalid;
    assign w_rd_req = bus.s_axi_arvalid;
    // With both pending, the direction not served last time wins
    assign w_acc_wr = w_idle && w_wr_req && (!w_rd_req || r_last_rd);
    assign w_acc_rd = w_idle && w_rd_req && !(w_wr_req && r_last_rd);
    assign w_accept = w_acc_wr || w_acc_rd;
    // Ack and err both terminate a cycle; err takes precedence in the datapath
    assign w_term   = w_busy && (bus.i_wb_ack || bus.i_wb_err);
    assign w_resp_taken = r_is_rd ? bus.s_axi_rready : bus.s_axi_bready;

    // Watchdog counting clocks with cyc high; absent when TIMEOUT is zero
    generate
        if (TIMEOUT > 0) begin : g_timeout
            localparam int TW = $clog2(TIMEOUT + 1);
            logic [TW-1:0] r_count;

            // Clear on accept, count every clock the cycle is open
            always_ff @(posedge i_clk) begin
                if (i_reset || w_accept) begin
                    r_count <= '0;
                end else if (w_busy) begin
                    r_count <= r_count + 1'b1;
                end
            end

            assign w_timeout = w_busy && (r_count == TW'(TIMEOUT - 1));
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_STB;
                end
            end
            S_STB: begin
                if (w_term || w_timeout) begin
                    w_state_next = S_RESP;
                end else if (!bus.i_wb_stall) begin
                    w_state_next = S_ACK;
                end
            end
            S_ACK: begin
                if (w_term || w_timeout) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (w_resp_taken) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Request capture on accept and response capture on cycle termination
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_adr     <= '0;
            r_dat     <= '0;
            r_sel     <= '0;
            r_we      <= 1'b0;
            r_is_rd   <= 1'b0;
            r_last_rd <= 1'b1;
            r_resp    <= C_OKAY;
            r_rdata   <= '0;
        end else begin
            if (w_accept) begin
                r_we      <= w_acc_wr;
                r_is_rd   <= w_acc_rd;
                r_last_rd <= w_acc_rd;
                if (w_acc_wr) begin
                    r_adr <= bus.s_axi_awaddr[AW-1:2];
                    r_dat <= bus.s_axi_wdata;
                    r_sel <= bus.s_axi_wstrb;
                end else begin
                    r_adr <= bus.s_axi_araddr[AW-1:2];
                    r_sel <= '1;
                end
            end
            if (w_term) begin
                r_resp <= bus.i_wb_err ? C_SLVERR : C_OKAY;
                if (r_is_rd) begin
                    r_rdata <= (bus.i_wb_ack && !bus.i_wb_err) ? bus.i_wb_data : '0;
                end
            end else if (w_timeout) begin
                r_resp <= C_SLVERR;
                if (r_is_rd) begin
                    r_rdata <= '0;
                end
            end
        end
    end

    assign bus.s_axi_awready = w_acc_wr;
    assign bus.s_axi_wready  = w_acc_wr;
    assign bus.s_axi_arready = w_acc_rd;
    assign bus.s_axi_bvalid  = (r_state == S_RESP) && !r_is_rd;
    assign bus.s_axi_bresp   = r_resp;
    assign bus.s_axi_rvalid  = (r_state == S_RESP) && r_is_rd;
    assign bus.s_axi_rresp   = r_resp;
    assign bus.s_axi_rdata   = r_rdata;

    assign bus.o_wb_cyc = w_busy;
    assign bus.o_wb_stb = (r_state == S_STB);
    assign bus.o_wb_we  = r_we;
    assign bus.o_wb_adr = r_adr;
    assign bus.o_wb_dat = r_dat;
    assign bus.o_wb_sel = r_sel;
endmodule
`default_nettype wire

// File: tb/tb_axlite_wb_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axlite_wb_master
//  Description : Directed bench for the AXI4-Lite to Wishbone bridge with a
//                hand-driven Wishbone slave and an 8-clock watchdog.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axlite_wb_master;
    localparam int AW = 28;
    localparam int DW = 32;

    logic i_clk;
    logic i_reset;
    int   n_checks;
    int   n_errors;

    axlite_wb_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    axlite_wb_master #(
        .C_AXI_ADDR_WIDTH (AW),
        .C_AXI_DATA_WIDTH (DW),
        .TIMEOUT          (8)
    ) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         cnt;
        int         rises;
        int         acks;
        logic       prev_cyc;
        logic [3:0] ord;
        logic       done;

        n_checks = 0;
        n_errors = 0;
        i_reset  = 1'b1;
        bus.s_axi_awvalid = 0; bus.s_axi_awaddr = '0; bus.s_axi_awprot = '0;
        bus.s_axi_wvalid  = 0; bus.s_axi_wdata  = '0; bus.s_axi_wstrb  = '0;
        bus.s_axi_bready  = 0;
        bus.s_axi_arvalid = 0; bus.s_axi_araddr = '0; bus.s_axi_arprot = '0;
        bus.s_axi_rready  = 0;
        bus.i_wb_ack = 0; bus.i_wb_stall = 0; bus.i_wb_err = 0; bus.i_wb_data = '0;
        tick; tick;
        i_reset = 1'b0;

        // Reset state
        chk("rst_cyc",    bus.o_wb_cyc,     0);
        chk("rst_stb",    bus.o_wb_stb,     0);
        chk("rst_bvalid", bus.s_axi_bvalid, 0);
        chk("rst_rvalid", bus.s_axi_rvalid, 0);
        chk("rst_resp",   bus.s_axi_rresp,  0);
        chk("rst_rdata",  bus.s_axi_rdata,  0);

        // 1: write 0x10 / CAFEF00D, slave acks in the strobe clock
        bus.s_axi_awaddr = 28'h10; bus.s_axi_wdata = 32'hCAFEF00D; bus.s_axi_wstrb = 4'hF;
        bus.s_axi_awvalid = 1; bus.s_axi_wvalid = 1; bus.s_axi_bready = 1;
        #1;
        chk("t1_awready", bus.s_axi_awready, 1);
        chk("t1_wready",  bus.s_axi_wready,  1);
        tick;
        bus.s_axi_awvalid = 0; bus.s_axi_wvalid = 0;
        chk("t1_cyc", bus.o_wb_cyc, 1);
        chk("t1_stb", bus.o_wb_stb, 1);
        chk("t1_we",  bus.o_wb_we,  1);
        chk("t1_adr", bus.o_wb_adr, 26'h4);
        chk("t1_sel", bus.o_wb_sel, 4'hF);
        chk("t1_dat", bus.o_wb_dat, 32'hCAFEF00D);
        bus.i_wb_ack = 1;
        tick;
        bus.i_wb_ack = 0;
        chk("t1_cyc_low", bus.o_wb_cyc,     0);
        chk("t1_bvalid",  bus.s_axi_bvalid, 1);
        chk("t1_bresp",   bus.s_axi_bresp,  2'b00);
        tick;
        chk("t1_bvalid_clr", bus.s_axi_bvalid, 0);
        bus.s_axi_bready = 0;

        // 2: read 0x8, stall 3 clocks, ack two clocks after strobe accepted
        bus.s_axi_araddr = 28'h8; bus.s_axi_arvalid = 1; bus.i_wb_stall = 1;
        #1;
        chk("t2_arready", bus.s_axi_arready, 1);
        tick;
        bus.s_axi_arvalid = 0;
        chk("t2_adr", bus.o_wb_adr, 26'h2);
        chk("t2_we",  bus.o_wb_we,  0);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.o_wb_stb) cnt++;
            tick;
        end
        bus.i_wb_stall = 0;
        if (bus.o_wb_stb) cnt++;
        tick;
        chk("t2_stb_clocks", cnt, 4);
        chk("t2_stb_low", bus.o_wb_stb, 0);
        chk("t2_cyc_hold", bus.o_wb_cyc, 1);
        tick;
        bus.i_wb_ack = 1; bus.i_wb_data = 32'h12345678;
        tick;
        bus.i_wb_ack = 0;
        chk("t2_cyc_low", bus.o_wb_cyc,     0);
        chk("t2_rvalid",  bus.s_axi_rvalid, 1);
        chk("t2_rdata",   bus.s_axi_rdata,  32'h12345678);
        chk("t2_rresp",   bus.s_axi_rresp,  2'b00);
        bus.i_wb_data = 32'hFFFFFFFF;
        tick;
        chk("t2_rvalid_hold", bus.s_axi_rvalid, 1);
        chk("t2_rdata_hold",  bus.s_axi_rdata,  32'h12345678);
        bus.s_axi_rready = 1;
        tick;
        chk("t2_rvalid_clr", bus.s_axi_rvalid, 0);
        bus.s_axi_rready = 0;

        // 3: write terminated by err, then a read with ack and err together
        bus.s_axi_awaddr = 28'h20; bus.s_axi_wdata = 32'h11111111; bus.s_axi_wstrb = 4'h3;
        bus.s_axi_awvalid = 1; bus.s_axi_wvalid = 1;
        tick;
        bus.s_axi_awvalid = 0; bus.s_axi_wvalid = 0;
        chk("t3_sel", bus.o_wb_sel, 4'h3);
        bus.i_wb_err = 1;
        tick;
        bus.i_wb_err = 0;
        chk("t3_cyc_low", bus.o_wb_cyc,     0);
        chk("t3_bvalid",  bus.s_axi_bvalid, 1);
        chk("t3_bresp",   bus.s_axi_bresp,  2'b10);
        bus.s_axi_bready = 1;
        tick;
        bus.s_axi_bready = 0;
        bus.s_axi_araddr = 28'h4; bus.s_axi_arvalid = 1;
        #1;
        chk("t3_next_arready", bus.s_axi_arready, 1);
        tick;
        bus.s_axi_arvalid = 0;
        bus.i_wb_ack = 1; bus.i_wb_err = 1; bus.i_wb_data = 32'hA5A5A5A5;
        tick;
        bus.i_wb_ack = 0; bus.i_wb_err = 0;
        chk("t3_ackerr_rresp", bus.s_axi_rresp, 2'b10);
        chk("t3_ackerr_rdata", bus.s_axi_rdata, 0);
        bus.s_axi_rready = 1;
        tick;
        bus.s_axi_rready = 0;

        // 4: write and read both pending for four transactions
        bus.s_axi_awaddr = 28'h100; bus.s_axi_araddr = 28'h200;
        bus.s_axi_wdata = 32'h55AA55AA; bus.s_axi_wstrb = 4'hF;
        bus.i_wb_data = 32'hDEADBEEF;
        bus.s_axi_awvalid = 1; bus.s_axi_wvalid = 1; bus.s_axi_arvalid = 1;
        bus.s_axi_bready = 1; bus.s_axi_rready = 1;
        prev_cyc = 0; rises = 0; acks = 0; ord = '0;
        for (int c = 0; c < 60 && acks < 4; c++) begin
            tick;
            if (bus.o_wb_cyc && !prev_cyc) begin
                if (rises < 4) ord[rises] = bus.o_wb_we;
                rises++;
            end
            prev_cyc = bus.o_wb_cyc;
            if (bus.o_wb_cyc) begin
                bus.i_wb_ack = 1;
                acks++;
                if (acks == 4) begin
                    bus.s_axi_awvalid = 0; bus.s_axi_wvalid = 0; bus.s_axi_arvalid = 0;
                    bus.s_axi_rready = 0;
                end
            end else begin
                bus.i_wb_ack = 0;
            end
        end
        tick;
        bus.i_wb_ack = 0;
        chk("t4_acks",  acks,  4);
        chk("t4_rises", rises, 4);
        chk("t4_order", ord,   4'b0101);
        chk("t4_last_rvalid", bus.s_axi_rvalid, 1);
        chk("t4_last_rdata",  bus.s_axi_rdata,  32'hDEADBEEF);
        bus.s_axi_rready = 1;
        tick;
        bus.s_axi_rready = 0; bus.s_axi_bready = 0;

        // 5: read with no ack, watchdog closes the cycle after 8 clocks
        bus.s_axi_araddr = 28'h40; bus.s_axi_arvalid = 1;
        tick;
        bus.s_axi_arvalid = 0;
        cnt = 0; done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (bus.o_wb_cyc) begin
                cnt++;
                tick;
            end else begin
                done = 1;
            end
        end
        chk("t5_cyc_clocks", cnt, 8);
        chk("t5_rvalid", bus.s_axi_rvalid, 1);
        chk("t5_rresp",  bus.s_axi_rresp,  2'b10);
        chk("t5_rdata",  bus.s_axi_rdata,  0);
        bus.s_axi_rready = 1;
        tick;
        bus.s_axi_rready = 0;

        // 6: reset while waiting for ack, response discarded
        bus.s_axi_araddr = 28'hC; bus.s_axi_arvalid = 1;
        tick;
        bus.s_axi_arvalid = 0;
        tick;
        chk("t6_in_ack_cyc", bus.o_wb_cyc, 1);
        chk("t6_in_ack_stb", bus.o_wb_stb, 0);
        i_reset = 1;
        tick;
        i_reset = 0;
        chk("t6_cyc_low", bus.o_wb_cyc,     0);
        chk("t6_rvalid",  bus.s_axi_rvalid, 0);
        tick;
        chk("t6_rvalid_stays", bus.s_axi_rvalid, 0);
        bus.s_axi_awvalid = 1; bus.s_axi_wvalid = 1; bus.s_axi_arvalid = 1;
        #1;
        chk("t6_rst_wr_first", bus.s_axi_awready, 1);
        chk("t6_rst_rd_wait",  bus.s_axi_arready, 0);
        bus.s_axi_awvalid = 0; bus.s_axi_wvalid = 0;
        #1;
        chk("t6_arready", bus.s_axi_arready, 1);
        tick;
        bus.s_axi_arvalid = 0;
        bus.i_wb_ack = 1; bus.i_wb_data = 32'h600DCAFE;
        tick;
        bus.i_wb_ack = 0;
        chk("t6_rvalid_new", bus.s_axi_rvalid, 1);
        chk("t6_rdata_new",  bus.s_axi_rdata,  32'h600DCAFE);
        bus.s_axi_rready = 1;
        tick;
        bus.s_axi_rready = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
